erasure_polyn_sequencer: RTL and testbench

//  Controller for the erasure-locator polynomial datapath in the RS decoder. Per codeword:
//  - pulls erasure positions from the position calculator over a valid/ready handshake;
//  - feeds them one per step into the locator datapath;
//  - reads back lambda(x) coefficients 0..N and streams them, indexed, to Berlekamp-Massey.

---
 rtl/erasure_polyn_sequencer.sv | 163 ++++++++++++++++
 tb/tb_erasure_polyn_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/erasure_polyn_sequencer.sv
// Erasure-locator sequencer: pulls erasure positions into the locator datapath,
// then streams the lambda(x) coefficients to Berlekamp-Massey. Optional FEED starvation timeout: ERASURE_SEQ_TIMEOUT_EN.
module erasure_polyn_sequencer #(
    parameter int WIDTH          = 5,
    parameter int NUM_COEFS      = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] num_erasures,
    input  logic [WIDTH-1:0] no_of_parity,
    input  logic             pos_valid,
    input  logic [7:0]       pos_data,
    output logic             pos_ready,
    output logic [7:0]       loc_erase_position,
    output logic             loc_erasure_ready,
    output logic             loc_send_polyn,
    input  logic [7:0]       loc_coef,
    input  logic             loc_coef_ready,
    output logic [7:0]       coef_out,
    output logic [WIDTH-1:0] coef_idx,
    output logic             coef_valid,
    output logic             coef_last,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [2:0]       state_dbg
);

    // Handshakes: a position moves when pos_valid & pos_ready at a rising edge;
    // a coefficient request is one loc_send_polyn cycle, answered by one loc_coef_ready cycle.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_FEED   = 3'd2,
        S_SETTLE = 3'd3,
        S_READ   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam int MAX_N = NUM_COEFS - 1;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_q, p_q, fed_q, k_q;
    logic             settle_q, pend_q;
    logic [7:0]       pos_q, coef_q;
    logic [WIDTH-1:0] idx_q;
    logic             strobe_q, coef_valid_q, coef_last_q;
    logic             xfer, send, take, timeout_hit;

    assign pos_ready = (state_q == S_FEED) && (fed_q < n_q);
    assign xfer      = pos_valid && pos_ready;
    // k_q runs to N+1 once the last coefficient has been taken, which stops requests.
    assign send      = (state_q == S_READ) && !pend_q && (k_q <= n_q);
    assign take      = (state_q == S_READ) && pend_q && loc_coef_ready;

`ifdef ERASURE_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_q;

    always_ff @(posedge clock) begin
        if (reset || state_q != S_FEED || xfer) begin
            to_q <= '0;
        end else if (pos_ready && !pos_valid) begin
            to_q <= to_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == S_FEED) && pos_ready && !pos_valid &&
                         (to_q == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_CHECK;
            S_CHECK: begin
                if (n_q > p_q || int'(n_q) > MAX_N) state_d = S_ERR;
                else if (n_q == '0)                 state_d = S_SETTLE;
                else                                state_d = S_FEED;
            end
            S_FEED: begin
                if (xfer && (fed_q + 1'b1) == n_q) state_d = S_SETTLE;
                else if (timeout_hit)              state_d = S_ERR;
            end
            S_SETTLE: if (settle_q) state_d = S_READ;
            S_READ:   if (coef_valid_q && coef_last_q) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            n_q          <= '0;
            p_q          <= '0;
            fed_q        <= '0;
            k_q          <= '0;
            settle_q     <= 1'b0;
            pend_q       <= 1'b0;
            pos_q        <= '0;
            strobe_q     <= 1'b0;
            coef_q       <= '0;
            idx_q        <= '0;
            coef_valid_q <= 1'b0;
            coef_last_q  <= 1'b0;
        end else begin
            strobe_q     <= 1'b0;
            coef_valid_q <= 1'b0;
            coef_last_q  <= 1'b0;
            if (state_q == S_IDLE && start) begin
                n_q      <= num_erasures;
                p_q      <= no_of_parity;
                fed_q    <= '0;
                k_q      <= '0;
                settle_q <= 1'b0;
                pend_q   <= 1'b0;
            end
            if (xfer) begin
                pos_q    <= pos_data;
                strobe_q <= 1'b1;
                fed_q    <= fed_q + 1'b1;
            end
            if (state_q == S_SETTLE) settle_q <= 1'b1;
            if (send) pend_q <= 1'b1;
            if (take) begin
                pend_q       <= 1'b0;
                coef_q       <= loc_coef;
                idx_q        <= k_q;
                coef_valid_q <= 1'b1;
                coef_last_q  <= (k_q == n_q);
                k_q          <= k_q + 1'b1;
            end
        end
    end

    assign loc_erase_position = pos_q;
    assign loc_erasure_ready  = strobe_q;
    assign loc_send_polyn     = send;
    assign coef_out           = coef_q;
    assign coef_idx           = idx_q;
    assign coef_valid         = coef_valid_q;
    assign coef_last          = coef_last_q;
    assign busy               = (state_q != S_IDLE);
    assign done               = (state_q == S_DONE);
    assign error              = (state_q == S_ERR);
    assign state_dbg          = state_q;

endmodule

// File: tb/tb_erasure_polyn_sequencer.sv
// Directed bench for erasure_polyn_sequencer: models the position source and the
// locator datapath, scoreboards positions and coefficients against expected queues.
module tb_erasure_polyn_sequencer;

    localparam int W  = 5;
    localparam int EW = 14;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] num_erasures, no_of_parity;
    logic         pos_valid;
    logic [7:0]   pos_data;
    logic         pos_ready;
    logic [7:0]   loc_erase_position;
    logic         loc_erasure_ready, loc_send_polyn;
    logic [7:0]   loc_coef;
    logic         loc_coef_ready;
    logic [7:0]   coef_out;
    logic [W-1:0] coef_idx;
    logic         coef_valid, coef_last, busy, done, error;
    logic [2:0]   state_dbg;

    erasure_polyn_sequencer #(.WIDTH(W), .NUM_COEFS(16), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset), .start(start),
        .num_erasures(num_erasures), .no_of_parity(no_of_parity),
        .pos_valid(pos_valid), .pos_data(pos_data), .pos_ready(pos_ready),
        .loc_erase_position(loc_erase_position), .loc_erasure_ready(loc_erasure_ready),
        .loc_send_polyn(loc_send_polyn), .loc_coef(loc_coef), .loc_coef_ready(loc_coef_ready),
        .coef_out(coef_out), .coef_idx(coef_idx), .coef_valid(coef_valid), .coef_last(coef_last),
        .busy(busy), .done(done), .error(error), .state_dbg(state_dbg)
    );

    // clock / reset block
    always #5 clock = ~clock;

    int tests_run = 0;
    int tests_failed = 0;

    logic [EW-1:0] exp_q[$];
    logic [7:0]    pos_exp_q[$];

    int pos_ready_cnt, done_cnt, error_cnt, strobe_cnt, coef_cnt;
    int cyc = 0;
    int first_strobe, last_strobe;
    int coef_lat = 1;
    logic [7:0] coef_base = 8'h00;
    int resp_idx = 0;
    bit spur = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        pos_ready_cnt = 0; done_cnt = 0; error_cnt = 0;
        strobe_cnt = 0; coef_cnt = 0; first_strobe = -1; last_strobe = -1;
    endtask

    task automatic expect_coefs(input int n, input logic [7:0] base);
        for (int j = 0; j <= n; j++)
            exp_q.push_back({(j == n) ? 1'b1 : 1'b0, 5'(j), base ^ 8'(j)});
    endtask

    // driver tasks
    task automatic do_start(input int n, input int p);
        num_erasures = 5'(n);
        no_of_parity = 5'(p);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_pos(input logic [7:0] d, input int gap);
        int budget = 0;
        pos_valid = 1'b1;
        pos_data  = d;
        while (!pos_ready && budget < 100) begin
            @(negedge clock);
            budget++;
        end
        if (budget >= 100) check("pos_ready_wait", 32'd0, 32'd1);
        @(negedge clock);
        pos_valid = 1'b0;
        repeat (gap) @(negedge clock);
    endtask

    task automatic wait_end(input int max_cyc, output bit got_done, output bit got_err);
        int n = 0;
        while (!done && !error && n < max_cyc) begin
            @(negedge clock);
            n++;
        end
        got_done = done;
        got_err  = error;
        if (n >= max_cyc) check("end_wait", 32'd0, 32'd1);
    endtask

    initial forever @(posedge clock) cyc++;

    // locator datapath model: answers each request coef_lat (>=1) cycles later
    initial begin
        loc_coef_ready = 1'b0;
        loc_coef = 8'h00;
        forever begin
            @(negedge clock);
            loc_coef_ready = 1'b0;
            if (spur) begin
                loc_coef = 8'hEE;
                loc_coef_ready = 1'b1;
                spur = 1'b0;
            end else if (loc_send_polyn && !reset) begin
                for (int i = 0; i < coef_lat; i++) begin
                    @(negedge clock);
                    loc_coef_ready = 1'b0;
                    check("one_outstanding", 32'(loc_send_polyn), 32'd0);
                end
                loc_coef = coef_base ^ 8'(resp_idx);
                resp_idx++;
                loc_coef_ready = 1'b1;
            end
        end
    end

    // scoreboard / monitor
    initial forever begin
        @(negedge clock);
        if (!reset) begin
            if (pos_ready) pos_ready_cnt++;
            if (done) done_cnt++;
            if (error) error_cnt++;
            if (loc_erasure_ready) begin
                strobe_cnt++;
                if (first_strobe < 0) first_strobe = cyc;
                last_strobe = cyc;
                if (pos_exp_q.size() == 0) check("strobe_unexpected", 32'd1, 32'd0);
                else check("strobe_pos", 32'(loc_erase_position), 32'(pos_exp_q.pop_front()));
            end
            if (coef_valid) begin
                coef_cnt++;
                if (exp_q.size() == 0) check("coef_unexpected", 32'd1, 32'd0);
                else check("coef_tuple", 32'({coef_last, coef_idx, coef_out}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit gd, ge;
        int n;
        reset = 1'b1; start = 1'b0; num_erasures = '0; no_of_parity = '0;
        pos_valid = 1'b0; pos_data = '0;
        clear_counts();
        repeat (3) @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pos_ready", 32'(pos_ready), 32'd0);
        check("rst_coef_valid", 32'(coef_valid), 32'd0);
        check("rst_outputs", 32'({done, error, loc_send_polyn, loc_erasure_ready, coef_last}), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // N=3, P=8, back-to-back positions
        clear_counts(); coef_base = 8'h30; resp_idx = 0; coef_lat = 1;
        expect_coefs(3, 8'h30);
        pos_exp_q.push_back(8'h02); pos_exp_q.push_back(8'h04); pos_exp_q.push_back(8'h08);
        do_start(3, 8);
        check("t1_busy_after_start", 32'(busy), 32'd1);
        send_pos(8'h02, 0); send_pos(8'h04, 0); send_pos(8'h08, 0);
        check("t1_pos_ready_drop", 32'(pos_ready), 32'd0);
        wait_end(200, gd, ge);
        check("t1_done", 32'(gd), 32'd1);
        check("t1_busy_in_done", 32'(busy), 32'd1);
        @(negedge clock);
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_done_pulse", 32'(done_cnt), 32'd1);
        check("t1_strobes", 32'(strobe_cnt), 32'd3);
        check("t1_back_to_back", 32'(last_strobe - first_strobe), 32'd2);
        check("t1_coef_cnt", 32'(coef_cnt), 32'd4);
        check("t1_exp_empty", 32'(exp_q.size()), 32'd0);

        // N=0, P=4: feed skipped, single coefficient
        clear_counts(); coef_base = 8'h81; resp_idx = 0;
        expect_coefs(0, 8'h81);
        do_start(0, 4);
        wait_end(100, gd, ge);
        check("t2_done", 32'(gd), 32'd1);
        check("t2_no_pos_ready", 32'(pos_ready_cnt), 32'd0);
        check("t2_coef_cnt", 32'(coef_cnt), 32'd1);

        // N=5 > P=4: error two cycles after start, pos_valid not consumed
        @(negedge clock);
        clear_counts();
        pos_valid = 1'b1; pos_data = 8'h55;
        do_start(5, 4);
        check("t3_busy_check", 32'(busy), 32'd1);
        check("t3_no_err_yet", 32'(error), 32'd0);
        @(negedge clock);
        check("t3_error", 32'(error), 32'd1);
        @(negedge clock);
        check("t3_error_pulse", 32'(error), 32'd0);
        check("t3_busy_drop", 32'(busy), 32'd0);
        pos_valid = 1'b0;
        check("t3_counts", 32'({8'(pos_ready_cnt), 8'(coef_cnt), 8'(strobe_cnt), 8'(error_cnt)}), 32'h0000_0001);

        // N=16 exceeds datapath capacity even with enough parity
        clear_counts();
        do_start(16, 20);
        wait_end(10, gd, ge);
        check("t4_cap_error", 32'(ge), 32'd1);
        @(negedge clock);
        check("t4_no_coef", 32'(coef_cnt), 32'd0);

        // N=2=P: gaps between positions, slow datapath, stray ready and start ignored
        clear_counts(); coef_base = 8'h5A; resp_idx = 0; coef_lat = 4;
        expect_coefs(2, 8'h5A);
        pos_exp_q.push_back(8'h11); pos_exp_q.push_back(8'h22);
        do_start(2, 2);
        send_pos(8'h11, 0);
        spur = 1'b1; start = 1'b1; num_erasures = 5'd7;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        send_pos(8'h22, 0);
        wait_end(300, gd, ge);
        check("t5_done", 32'(gd), 32'd1);
        check("t5_strobes", 32'(strobe_cnt), 32'd2);
        check("t5_coef_cnt", 32'(coef_cnt), 32'd3);
        check("t5_exp_empty", 32'(exp_q.size()), 32'd0);

        // N=15, P=16: largest codeword
        @(negedge clock);
        clear_counts(); coef_base = 8'hC3; resp_idx = 0; coef_lat = 1;
        expect_coefs(15, 8'hC3);
        for (int j = 1; j <= 15; j++) pos_exp_q.push_back(8'(j));
        do_start(15, 16);
        for (int j = 1; j <= 15; j++) send_pos(8'(j), 0);
        wait_end(400, gd, ge);
        check("t6_done", 32'(gd), 32'd1);
        check("t6_strobes", 32'(strobe_cnt), 32'd15);
        check("t6_coef_cnt", 32'(coef_cnt), 32'd16);

        // reset during READ after coefficient 1
        @(negedge clock);
        clear_counts(); coef_base = 8'h71; resp_idx = 0; coef_lat = 2;
        expect_coefs(3, 8'h71);
        pos_exp_q.push_back(8'h03); pos_exp_q.push_back(8'h05); pos_exp_q.push_back(8'h07);
        do_start(3, 6);
        send_pos(8'h03, 0); send_pos(8'h05, 0); send_pos(8'h07, 0);
        n = 0;
        while (!(coef_valid && coef_idx == 5'd1) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("t7_reached_idx1", 32'(n < 200), 32'd1);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clock);
        check("t7_rst_coef_valid", 32'(coef_valid), 32'd0);
        check("t7_rst_busy", 32'(busy), 32'd0);
        check("t7_rst_outputs", 32'({done, error, loc_send_polyn, pos_ready}), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        clear_counts();
        repeat (12) @(negedge clock);
        check("t7_no_done", 32'(done_cnt), 32'd0);
        check("t7_no_coef", 32'(coef_cnt), 32'd0);
        coef_base = 8'h0F; resp_idx = 0; coef_lat = 1;
        expect_coefs(1, 8'h0F);
        pos_exp_q.push_back(8'h09);
        do_start(1, 2);
        send_pos(8'h09, 0);
        wait_end(100, gd, ge);
        check("t7_restart_done", 32'(gd), 32'd1);
        check("t7_restart_coefs", 32'(coef_cnt), 32'd2);

`ifdef ERASURE_SEQ_TIMEOUT_EN
        // one position, then starvation
        @(negedge clock);
        clear_counts();
        pos_exp_q.push_back(8'h44);
        do_start(2, 4);
        send_pos(8'h44, 0);
        n = 0;
        while (!error && n < 50) begin
            if (pos_ready && !pos_valid) n++;
            @(negedge clock);
        end
        check("t8_timeout_error", 32'(error), 32'd1);
        check("t8_starved_cycles", 32'(n), 32'd8);
        check("t8_no_coef", 32'(coef_cnt), 32'd0);
`endif

        repeat (2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
